// File: rtl/ppu_lcd_timing.sv
// ppu_lcd_timing: parametrised LCD line/frame sequencer for the PPU.
// Walks the H/V raster, sequences OAM scan / pixel transfer / HBLANK / VBLANK,
// tracks the pixel X position through a stall-stretched mode 3, and raises
// the STAT and VBL interrupt pulses.
module ppu_lcd_timing #(
  parameter int HW        = 9,
  parameter int VW        = 8,
  parameter int H_TOTAL   = 456,
  parameter int V_TOTAL   = 154,
  parameter int V_ACTIVE  = 144,
  parameter int H_PIXELS  = 160,
  parameter int MODE2_LEN = 80,
  parameter int MODE3_PRE = 12
) (
  input  logic          ppu_clk,
  input  logic          ppu_reset,
  input  logic          lcd_on,
  input  logic          mode3_stall,
  input  logic [VW-1:0] lyc,
  input  logic [3:0]    stat_sel,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic [7:0]    px,
  output logic [1:0]    mode,
  output logic          ppu_mode2,
  output logic          ppu_mode3,
  output logic          vbl,
  output logic          lyc_match,
  output logic          line_start,
  output logic          frame_start,
  output logic          ppu_int_stat,
  output logic          ppu_int_vbl,
  output logic          overrun
);

  // Geometry sanity: counters must hold their ranges and a full mode 3 must fit in a line.
  if (H_TOTAL > (1 << HW)) begin : g_chk_htotal
    $error("ppu_lcd_timing: H_TOTAL does not fit in HW bits");
  end
  if (V_TOTAL > (1 << VW)) begin : g_chk_vtotal
    $error("ppu_lcd_timing: V_TOTAL does not fit in VW bits");
  end
  if (MODE2_LEN + MODE3_PRE + H_PIXELS >= H_TOTAL - 1) begin : g_chk_line
    $error("ppu_lcd_timing: mode 2 + mode 3 do not fit in a line");
  end
  if (V_ACTIVE >= V_TOTAL) begin : g_chk_vactive
    $error("ppu_lcd_timing: frame needs at least one VBLANK line");
  end
  if (H_PIXELS > 256 || H_PIXELS < 1) begin : g_chk_pixels
    $error("ppu_lcd_timing: H_PIXELS must be 1..256 for the 8-bit px counter");
  end

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_FORCE  = HW'(H_TOTAL - 2);
  localparam logic [HW-1:0] M2_LAST  = HW'(MODE2_LEN - 1);
  localparam logic [HW-1:0] PRE_LEN  = HW'(MODE3_PRE);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VIS_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_VBL    = VW'(V_ACTIVE);
  localparam logic [7:0]    PX_LAST  = 8'(H_PIXELS - 1);

  typedef enum logic [2:0] {IDLE, MODE2, MODE3, HBLANK, VBLANK} state_t;

  state_t        state, state_next;
  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic [7:0]    px_next;
  logic [HW-1:0] warm, warm_next;
  logic          overrun_next;
  logic          lyc_match_next;
  logic          stat_line, stat_prev, stat_prev_next;
  logic          h_wrap, v_wrap;

  assign h_wrap = (h == H_LAST);
  assign v_wrap = (v == V_LAST);

  // Next-state logic: raster counters, mode sequencing, mode-3 warm-up/pixel count and forced end.
  always_comb begin
    state_next   = state;
    h_next       = h;
    v_next       = v;
    px_next      = px;
    warm_next    = warm;
    overrun_next = overrun;
    if (state == IDLE) begin
      h_next    = '0;
      v_next    = '0;
      px_next   = '0;
      warm_next = '0;
      if (lcd_on) state_next = MODE2;
    end else if (!lcd_on) begin
      state_next = IDLE;
      h_next     = '0;
      v_next     = '0;
      px_next    = '0;
      warm_next  = '0;
    end else begin
      h_next = h_wrap ? '0 : h + HW'(1);
      if (h_wrap) v_next = v_wrap ? '0 : v + VW'(1);
      case (state)
        MODE2: begin
          if (h == M2_LAST) state_next = MODE3;
        end
        MODE3: begin
          if (warm != PRE_LEN) begin
            warm_next = warm + HW'(1);
          end else if (!mode3_stall) begin
            if (px == PX_LAST) state_next = HBLANK;
            else               px_next    = px + 8'd1;
          end
          if (state_next == MODE3 && h == H_FORCE) begin
            state_next   = HBLANK;
            overrun_next = 1'b1;
          end
          if (state_next == HBLANK) begin
            px_next   = '0;
            warm_next = '0;
          end
        end
        HBLANK: begin
          if (h_wrap) state_next = (v == VIS_LAST) ? VBLANK : MODE2;
        end
        VBLANK: begin
          if (h_wrap && v_wrap) state_next = MODE2;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // STAT source OR-ing; HBLANK counts as mode 0 but IDLE does not.
  always_comb begin
    stat_line = (stat_sel[0] && state == HBLANK) ||
                (stat_sel[1] && state == VBLANK) ||
                (stat_sel[2] && state == MODE2)  ||
                (stat_sel[3] && lyc_match);
    lyc_match_next = (state != IDLE) && lcd_on && (v == lyc);
    stat_prev_next = (state_next == IDLE) ? 1'b0 : stat_line;
  end

  // State and counter registers with synchronous reset; overrun survives LCD-off.
  always_ff @(posedge ppu_clk) begin
    if (ppu_reset) begin
      state     <= IDLE;
      h         <= '0;
      v         <= '0;
      px        <= '0;
      warm      <= '0;
      overrun   <= 1'b0;
      lyc_match <= 1'b0;
      stat_prev <= 1'b0;
    end else begin
      state     <= state_next;
      h         <= h_next;
      v         <= v_next;
      px        <= px_next;
      warm      <= warm_next;
      overrun   <= overrun_next;
      lyc_match <= lyc_match_next;
      stat_prev <= stat_prev_next;
    end
  end

  // STAT mode bits decoded from the sequencer state.
  always_comb begin
    mode = 2'd0;
    case (state)
      MODE2:   mode = 2'd2;
      MODE3:   mode = 2'd3;
      VBLANK:  mode = 2'd1;
      default: mode = 2'd0;
    endcase
  end

  assign ppu_mode2    = (state == MODE2);
  assign ppu_mode3    = (state == MODE3);
  assign vbl          = (state == VBLANK);
  assign line_start   = (state != IDLE) && (h == '0);
  assign frame_start  = line_start && (v == '0);
  assign ppu_int_vbl  = (state == VBLANK) && (h == '0) && (v == V_VBL);
  assign ppu_int_stat = stat_line && !stat_prev;

endmodule
